// File: rtl/riscv_mem_pkg.sv
// Shared types and default sizes for the unified instruction/data memory arbiter.
package riscv_mem_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    // Saturation ceiling for the optional stall counters.
    localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between the fetch (IF) and load/store (MEM)
// stages of the pipeline. One transaction is outstanding at a time; the data port has
// fixed priority because the MEM-stage instruction is older. Read data and completion
// pulses pass straight through from the memory in the response cycle.
// Optional build macro: MEM_ARB_PERF_EN adds saturating stall-cycle counters
// perf_if_stall / perf_dm_stall.
module unified_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_if_stall,
    output logic [31:0]   perf_dm_stall
`endif
);

    arb_state_t state;
    logic       discard;
    arb_owner_t owner;
    logic       running;
    logic       accept;
    logic       store_done;
    logic       load_done;
    logic       rsp_valid;

    // Request side: pick the winner in IDLE and present it to the memory.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        owner     = dm_req ? OWN_DM : OWN_IF;
        // NOTE: outputs are qualified with reset so the whole interface reads 0 while in reset.
        running   = reset;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (running && (state == IDLE) && (dm_req || if_req)) begin
            mem_req = 1'b1;
            if (owner == OWN_DM) begin
                mem_we    = dm_we;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
            end else begin
                mem_addr  = if_addr;
            end
        end
        accept     = mem_req && mem_ready;
        store_done = accept && (owner == OWN_DM) && dm_we;
    end

    // Response side: route memory read data to whichever stage owns the transaction.
    always_comb begin
        rsp_valid = running && mem_rvalid;
        load_done = rsp_valid && (state == WAIT_DM);
        if_rvalid = rsp_valid && (state == WAIT_IF) && !discard && if_req;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_done   = load_done || store_done;
        dm_rdata  = load_done ? mem_rdata : '0;
        stall_if  = running && if_req && !if_rvalid;
        stall_mem = running && dm_req && !dm_done;
    end

    // Transaction sequencer: track the single outstanding read and flushed fetches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            discard <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    // Stores complete at accept; only reads wait for mem_rvalid.
                    if (accept && !store_done) begin
                        state <= (owner == OWN_DM) ? WAIT_DM : WAIT_IF;
                    end
                end
                WAIT_IF: begin
                    if (mem_rvalid) begin
                        state   <= IDLE;
                        discard <= 1'b0;
                    end else if (!if_req) begin
                        // Fetch withdrawn by a flush: the returning word must be dropped.
                        discard <= 1'b1;
                    end
                end
                WAIT_DM: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    discard <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Saturating counters of cycles each stage spends stalled on the memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_if_stall <= '0;
            perf_dm_stall <= '0;
        end else begin
            if (stall_if && (perf_if_stall != PERF_MAX)) begin
                perf_if_stall <= perf_if_stall + 32'd1;
            end
            if (stall_mem && (perf_dm_stall != PERF_MAX)) begin
                perf_dm_stall <= perf_dm_stall + 32'd1;
            end
        end
    end
`endif

    // A data request must stay asserted until its completion pulse.
    dm_req_held : assert property (@(posedge clk) disable iff (!reset)
                                   (dm_req && !dm_done) |=> dm_req);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed testbench for unified_mem_arbiter. Completion pulses are checked by a
// scoreboard: the expected owner/data is queued when the memory response is driven
// and popped when if_rvalid or dm_done fires. Define MEM_ARB_PERF_EN to also check
// the stall counters.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall;
    logic [31:0] perf_dm_stall;
`endif

    typedef struct {
        logic        is_dm;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    unified_mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_done    (dm_done),
        .dm_rdata   (dm_rdata),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_stall (perf_if_stall),
        .perf_dm_stall (perf_dm_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive a new cycle's inputs just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic is_dm, input logic chk_data, input logic [31:0] data);
        exp_t e;
        e.is_dm    = is_dm;
        e.chk_data = chk_data;
        e.data     = data;
        sb_q.push_back(e);
    endtask

    // Scoreboard consumer: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (if_rvalid || dm_done) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_pulse", {30'd0, if_rvalid, dm_done}, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_owner_dm", {31'd0, dm_done}, {31'd0, sb_e.is_dm});
                if (sb_e.chk_data) begin
                    check("sb_rdata", dm_done ? dm_rdata : if_rdata, sb_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        dm_addr    = '0;
        dm_wdata   = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Reset state.
        repeat (2) mid();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("rst_dm_done", {31'd0, dm_done}, 32'd0);
        check("rst_stalls", {30'd0, stall_if, stall_mem}, 32'd0);
        step();
        reset = 1'b1;

        // 1: fetch only, memory latency 1.
        step();
        if_req = 1'b1; if_addr = 32'h0; mem_ready = 1'b1;
        mid();
        check("t1_mem_req", {31'd0, mem_req}, 32'd1);
        check("t1_mem_addr", mem_addr, 32'h0);
        check("t1_mem_we", {31'd0, mem_we}, 32'd0);
        check("t1_stall_if_req", {31'd0, stall_if}, 32'd1);
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        push_exp(1'b0, 1'b1, 32'h0050_0093);
        mid();
        check("t1_mem_req_wait", {31'd0, mem_req}, 32'd0);
        check("t1_stall_if_rsp", {31'd0, stall_if}, 32'd0);
        step();
        if_req = 1'b0; mem_rvalid = 1'b0;
        mid();
        check("t1_stall_if_after", {31'd0, stall_if}, 32'd0);

        // 2: simultaneous fetch and load; the load goes first.
        step();
        if_req = 1'b1; if_addr = 32'h4;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; mem_ready = 1'b1;
        mid();
        check("t2_mem_addr_dm", mem_addr, 32'h100);
        check("t2_mem_we", {31'd0, mem_we}, 32'd0);
        check("t2_stalls_both", {30'd0, stall_if, stall_mem}, 32'd3);
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        push_exp(1'b1, 1'b1, 32'hCAFE_0001);
        mid();
        check("t2_mem_req_wait", {31'd0, mem_req}, 32'd0);
        check("t2_stalls_dm_rsp", {30'd0, stall_if, stall_mem}, 32'd2);
        step();
        dm_req = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b1;
        mid();
        check("t2_mem_req_if", {31'd0, mem_req}, 32'd1);
        check("t2_mem_addr_if", mem_addr, 32'h4);
        check("t2_stall_if_still", {31'd0, stall_if}, 32'd1);
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        push_exp(1'b0, 1'b1, 32'h1111_1111);
        mid();
        check("t2_stall_if_rsp", {31'd0, stall_if}, 32'd0);
        step();
        if_req = 1'b0; mem_rvalid = 1'b0;

        // 3: store completes at accept, fetch served the next cycle.
        step();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h8; mem_ready = 1'b1;
        push_exp(1'b1, 1'b0, 32'h0);
        mid();
        check("t3_mem_we", {31'd0, mem_we}, 32'd1);
        check("t3_mem_addr", mem_addr, 32'h200);
        check("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("t3_stalls", {30'd0, stall_if, stall_mem}, 32'd2);
        step();
        dm_req = 1'b0; dm_we = 1'b0;
        mid();
        check("t3_if_req_next", {31'd0, mem_req}, 32'd1);
        check("t3_if_addr_next", mem_addr, 32'h8);
        check("t3_if_we", {31'd0, mem_we}, 32'd0);
        check("t3_if_wdata", mem_wdata, 32'h0);
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
        push_exp(1'b0, 1'b1, 32'h2222_2222);
        step();
        if_req = 1'b0; mem_rvalid = 1'b0;

        // 4: fetch flushed while outstanding; its data is dropped.
        step();
        if_req = 1'b1; if_addr = 32'h8; mem_ready = 1'b1;
        mid();
        check("t4_mem_addr", mem_addr, 32'h8);
        step();
        if_req = 1'b0; mem_ready = 1'b0;
        mid();
        check("t4_flush_stall_if", {31'd0, stall_if}, 32'd0);
        step();
        step();
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b1;
        mid();
        check("t4_dropped_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("t4_no_req_in_wait", {31'd0, mem_req}, 32'd0);
        check("t4_new_stall_if", {31'd0, stall_if}, 32'd1);
        step();
        mem_rvalid = 1'b0;
        mid();
        check("t4_new_req", {31'd0, mem_req}, 32'd1);
        check("t4_new_addr", mem_addr, 32'h40);
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
        push_exp(1'b0, 1'b1, 32'h3333_3333);
        step();
        if_req = 1'b0; mem_rvalid = 1'b0;

        // 5: backpressure, then reset while a load is outstanding.
        step();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid();
            check("t5_bp_req", {31'd0, mem_req}, 32'd1);
            check("t5_bp_addr", mem_addr, 32'h300);
            check("t5_bp_stall_mem", {31'd0, stall_mem}, 32'd1);
            step();
        end
        mem_ready = 1'b1;
        mid();
        check("t5_accept_req", {31'd0, mem_req}, 32'd1);
        step();
        mem_ready = 1'b0;
        mid();
        check("t5_wait_dm_req", {31'd0, mem_req}, 32'd0);
        check("t5_wait_dm_stall", {31'd0, stall_mem}, 32'd1);
        step();
        reset = 1'b0;
        #1;
        check("t5_rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("t5_rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("t5_rst_mem_addr", mem_addr, 32'h0);
        check("t5_rst_mem_wdata", mem_wdata, 32'h0);
        check("t5_rst_pulses", {30'd0, if_rvalid, dm_done}, 32'd0);
        check("t5_rst_stalls", {30'd0, stall_if, stall_mem}, 32'd0);
        check("t5_rst_rdata", if_rdata | dm_rdata, 32'h0);
        step();
        reset = 1'b1; dm_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h4444_4444;
        mid();
        check("t5_stale_dm_done", {31'd0, dm_done}, 32'd0);
        check("t5_stale_mem_req", {31'd0, mem_req}, 32'd0);
        check("t5_stale_stall_mem", {31'd0, stall_mem}, 32'd0);
        step();
        mem_rvalid = 1'b0;

        // 6: five fetch-stall cycles and two data-stall cycles since reset.
        step();
        if_req = 1'b1; if_addr = 32'hC; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
        mem_ready = 1'b0;
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        push_exp(1'b1, 1'b1, 32'h5555_5555);
        step();
        dm_req = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b1;
        mid();
        check("t6_fetch_addr", mem_addr, 32'hC);
        step();
        mem_ready = 1'b0;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h6666_6666;
        push_exp(1'b0, 1'b1, 32'h6666_6666);
        step();
        if_req = 1'b0; mem_rvalid = 1'b0;
`ifdef MEM_ARB_PERF_EN
        mid();
        check("t6_perf_if_stall", perf_if_stall, 32'd5);
        check("t6_perf_dm_stall", perf_dm_stall, 32'd2);
`endif

        repeat (3) step();
        check("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
